// File: rtl/tcm_arbiter.sv
// rtl/tcm_arbiter.sv - two-port req/gnt arbiter in front of a single-port TCM
// Port 0 has priority; a starvation counter forces port 1 after STARVE_MAX lost cycles.
module tcm_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 15,
  parameter int STARVE_MAX = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    p0_req_i,
  output logic                    p0_gnt_o,
  input  logic [ADDR_WIDTH-1:0]   p0_addr_i,
  input  logic [DATA_WIDTH-1:0]   p0_wdata_i,
  input  logic                    p0_we_i,
  input  logic [DATA_WIDTH/8-1:0] p0_be_i,
  output logic                    p0_rvalid_o,
  output logic [DATA_WIDTH-1:0]   p0_rdata_o,
  input  logic                    p1_req_i,
  output logic                    p1_gnt_o,
  input  logic [ADDR_WIDTH-1:0]   p1_addr_i,
  input  logic [DATA_WIDTH-1:0]   p1_wdata_i,
  input  logic                    p1_we_i,
  input  logic [DATA_WIDTH/8-1:0] p1_be_i,
  output logic                    p1_rvalid_o,
  output logic [DATA_WIDTH-1:0]   p1_rdata_o,
  output logic                    tcm_en_o,
  output logic [ADDR_WIDTH-1:0]   tcm_addr_o,
  output logic [DATA_WIDTH-1:0]   tcm_wdata_o,
  output logic                    tcm_we_o,
  output logic [DATA_WIDTH/8-1:0] tcm_be_o,
  input  logic [DATA_WIDTH-1:0]   tcm_rdata_i
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0]         STARVE_LIM = SW'(STARVE_MAX);
  localparam logic [ADDR_WIDTH-1:0] WORD_MASK  = ~ADDR_WIDTH'(3);

  logic [SW-1:0]         starve_cnt;
  logic                  rsel_q;
  logic                  rwe_q;
  logic                  rvalid_q;
  logic [ADDR_WIDTH-1:0] addr_mux;

  always_comb begin
    p0_gnt_o = 1'b0;
    p1_gnt_o = 1'b0;
    if (!rst_i) begin
      if (p1_req_i && (!p0_req_i || starve_cnt == STARVE_LIM)) begin
        p1_gnt_o = 1'b1;
      end else if (p0_req_i) begin
        p0_gnt_o = 1'b1;
      end
    end
  end

  always_comb begin
    tcm_en_o    = p0_gnt_o | p1_gnt_o;
    addr_mux    = '0;
    tcm_wdata_o = '0;
    tcm_we_o    = 1'b0;
    tcm_be_o    = '0;
    if (p1_gnt_o) begin
      addr_mux    = p1_addr_i;
      tcm_wdata_o = p1_wdata_i;
      tcm_we_o    = p1_we_i;
      tcm_be_o    = p1_be_i;
    end else if (p0_gnt_o) begin
      addr_mux    = p0_addr_i;
      tcm_wdata_o = p0_wdata_i;
      tcm_we_o    = p0_we_i;
      tcm_be_o    = p0_be_i;
    end
    tcm_addr_o = addr_mux & WORD_MASK;
  end

  // Counts p0 wins while p1 waits; saturates so p1 stays forced until served.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      starve_cnt <= '0;
    end else if (p1_gnt_o || !p1_req_i) begin
      starve_cnt <= '0;
    end else if (p0_gnt_o && starve_cnt != STARVE_LIM) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rvalid_q <= 1'b0;
      rsel_q   <= 1'b0;
      rwe_q    <= 1'b0;
    end else begin
      rvalid_q <= tcm_en_o;
      rsel_q   <= p1_gnt_o;
      rwe_q    <= tcm_we_o;
    end
  end

  // Gating with rst_i drops the response of a grant made the cycle before reset.
  assign p0_rvalid_o = rvalid_q & ~rsel_q & ~rst_i;
  assign p1_rvalid_o = rvalid_q &  rsel_q & ~rst_i;
  assign p0_rdata_o  = (p0_rvalid_o && !rwe_q) ? tcm_rdata_i : '0;
  assign p1_rdata_o  = (p1_rvalid_o && !rwe_q) ? tcm_rdata_i : '0;

endmodule
